// File: rtl/riscv_core_pkg.sv
// Shared types for the RV64M multiply/divide unit: op encodings, FSM states, word width.
// No logic of its own, so it has no latency.
// No backpressure concerns at this level.
package riscv_core_pkg;

    // Encoding matches funct3 of the M-extension instructions.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    // Width of the W-form operands and results.
    localparam int WORD_W = 32;

endpackage

// File: rtl/riscv_core_div_iter.sv
// Restoring divider datapath: one shift/subtract step per enabled cycle on unsigned magnitudes.
// Latency is count_init steps after start; next-step values are exposed combinationally.
// No backpressure: the owner decides when to start and when to step.
module riscv_core_div_iter
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int CW   = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [CW-1:0]   count_init,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next,
    output logic [CW-1:0]   count
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   rem_sh;
    logic            ge;

    // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    // The remainder always stays below the divisor, so the shifted value fits in XLEN+1 bits
    // and the difference (when taken) fits back in XLEN bits.
    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        ge       = (rem_sh >= {1'b0, dvs_q});
        rem_next = ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
        quo_next = {quo_q[XLEN-2:0], ge};
    end

    // Load operands on start; advance one step per enable. The quotient register doubles as the
    // dividend shifter: dividend bits leave at the top, quotient bits enter at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            count <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            count <= count_init;
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/riscv_core_muldiv.sv
// Multi-cycle RV64M unit: registered multiplier, iterative restoring divider, W-form support.
// Latency: MUL 2 cycles, DIV XLEN+1, DIVW 33, divide special cases 1 (accept to done).
// Single op in flight: ready only in IDLE; valid while busy is ignored; flush kills the op.
module riscv_core_muldiv
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_md_valid,
    input  logic [2:0]      i_md_op,
    input  logic            i_md_isword,
    input  logic [XLEN-1:0] i_md_srcA,
    input  logic [XLEN-1:0] i_md_srcB,
    input  logic            i_md_flush,
    output logic            o_md_ready,
    output logic            o_md_busy,
    output logic            o_md_done,
    output logic [XLEN-1:0] o_md_result
);

    localparam int   CW   = $clog2(XLEN) + 1;
    // W-forms only exist on a 64-bit datapath; on XLEN=32 the isword flag is ignored.
    localparam logic W_OK = (XLEN == 64);

    function automatic logic [XLEN-1:0] sext_w(input logic [WORD_W-1:0] v);
        logic [XLEN-1:0] r;
        r             = {XLEN{v[WORD_W-1]}};
        r[WORD_W-1:0] = v;
        return r;
    endfunction

    md_state_e       state_q, state_d;
    md_op_e          op_in, op_q;
    logic            word_in, word_q;
    logic [XLEN-1:0] a_q, b_q;
    logic            q_neg_q, r_neg_q;

    logic            accept, start, step;
    logic            sgn_in, sa, sb, b_zero, ovf, special;
    logic [XLEN-1:0] spec_val, dvd_mag, dvs_mag;
    logic [CW-1:0]   count_init, count;
    logic [XLEN-1:0] quo_next, rem_next;

    logic [2*XLEN-1:0] ea, eb, prod;
    logic [XLEN-1:0]   mul_res, div_v, div_res, res_val;
    logic              res_load;

    // Decode the incoming request: signedness, special cases and divider magnitudes.
    always_comb begin
        op_in      = md_op_e'(i_md_op);
        word_in    = i_md_isword & W_OK;
        sgn_in     = i_md_op[2] & ~i_md_op[0];
        sa         = word_in ? i_md_srcA[WORD_W-1] : i_md_srcA[XLEN-1];
        sb         = word_in ? i_md_srcB[WORD_W-1] : i_md_srcB[XLEN-1];
        b_zero     = word_in ? (i_md_srcB[WORD_W-1:0] == '0) : (i_md_srcB == '0);
        ovf        = sgn_in & (word_in
                   ? ((i_md_srcA[WORD_W-1:0] == 32'h8000_0000) && (i_md_srcB[WORD_W-1:0] == 32'hFFFF_FFFF))
                   : ((i_md_srcA == {1'b1, {(XLEN-1){1'b0}}}) && (&i_md_srcB)));
        special    = i_md_op[2] & (b_zero | ovf);

        // Divide by zero: quotient all ones, remainder = dividend. Overflow: quotient = dividend, remainder 0.
        if (b_zero) begin
            spec_val = i_md_op[1] ? (word_in ? sext_w(i_md_srcA[WORD_W-1:0]) : i_md_srcA) : '1;
        end else begin
            spec_val = i_md_op[1] ? '0 : (word_in ? sext_w(i_md_srcA[WORD_W-1:0]) : i_md_srcA);
        end

        // W-form dividend sits in the top half so 32 MSB-first steps consume exactly its 32 bits.
        dvd_mag = '0;
        dvs_mag = '0;
        if (word_in) begin
            dvd_mag[WORD_W-1:0] = (sgn_in & sa) ? -i_md_srcA[WORD_W-1:0] : i_md_srcA[WORD_W-1:0];
            dvs_mag[WORD_W-1:0] = (sgn_in & sb) ? -i_md_srcB[WORD_W-1:0] : i_md_srcB[WORD_W-1:0];
            dvd_mag             = dvd_mag << (XLEN - WORD_W);
        end else begin
            dvd_mag = (sgn_in & sa) ? -i_md_srcA : i_md_srcA;
            dvs_mag = (sgn_in & sb) ? -i_md_srcB : i_md_srcB;
        end
        count_init = word_in ? CW'(WORD_W) : CW'(XLEN);
    end

    // Next-state logic; flush overrides everything and returns to IDLE without a done pulse.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        start   = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_md_valid && !i_md_flush) begin
                    accept = 1'b1;
                    if (!i_md_op[2]) begin
                        state_d = MUL;
                    end else if (special) begin
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                        start   = 1'b1;
                    end
                end
            end
            MUL:  state_d = DONE;
            DIV: begin
                step = 1'b1;
                if (count == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_md_flush) begin
            state_d = IDLE;
            step    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the accepted op and the sign fix-up flags for the divider.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q    <= OP_MUL;
            word_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (accept) begin
            op_q    <= op_in;
            word_q  <= word_in;
            a_q     <= i_md_srcA;
            b_q     <= i_md_srcB;
            q_neg_q <= sgn_in & (sa ^ sb);
            r_neg_q <= sgn_in & sa;
        end
    end

    riscv_core_div_iter #(
        .XLEN (XLEN),
        .CW   (CW)
    ) u_div_iter (
        .clk        (i_clk),
        .rst        (i_rst),
        .start      (start),
        .step       (step),
        .dividend   (dvd_mag),
        .divisor    (dvs_mag),
        .count_init (count_init),
        .quo_next   (quo_next),
        .rem_next   (rem_next),
        .count      (count)
    );

    // Product, divider sign fix-up and selection of the value to commit into the result register.
    always_comb begin
        ea   = {{XLEN{a_q[XLEN-1] & ((op_q == OP_MULH) || (op_q == OP_MULHSU))}}, a_q};
        eb   = {{XLEN{b_q[XLEN-1] & (op_q == OP_MULH)}}, b_q};
        prod = ea * eb;
        // A W-form high-half multiply has no meaning; it degrades to MULW.
        if ((op_q == OP_MUL) || word_q) begin
            mul_res = word_q ? sext_w(prod[WORD_W-1:0]) : prod[XLEN-1:0];
        end else begin
            mul_res = prod[2*XLEN-1:XLEN];
        end

        div_v   = op_q[1] ? rem_next : quo_next;
        div_v   = (op_q[1] ? r_neg_q : q_neg_q) ? -div_v : div_v;
        div_res = word_q ? sext_w(div_v[WORD_W-1:0]) : div_v;

        res_load = 1'b0;
        res_val  = mul_res;
        if (accept && special) begin
            res_load = 1'b1;
            res_val  = spec_val;
        end else if ((state_q == MUL) && !i_md_flush) begin
            res_load = 1'b1;
        end else if ((state_q == DIV) && (state_d == DONE)) begin
            res_load = 1'b1;
            res_val  = div_res;
        end
    end

    // Result holds its value until the next completed op.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_md_result <= '0;
        end else if (res_load) begin
            o_md_result <= res_val;
        end
    end

    assign o_md_ready = (state_q == IDLE);
    assign o_md_busy  = (state_q != IDLE);
    assign o_md_done  = (state_q == DONE);

endmodule

// File: tb/tb_riscv_core_muldiv.sv
// Directed bench for riscv_core_muldiv: results and latencies against hand-computed values.
// Covers MUL family, DIV/REM (64 and W forms), special cases, flush, busy-valid and reset.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_riscv_core_muldiv;

    typedef struct packed {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic [7:0]  lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        md_valid;
    logic [2:0]  md_op;
    logic        md_isword;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic        md_flush;
    logic        md_ready;
    logic        md_busy;
    logic        md_done;
    logic [63:0] md_result;

    int n_vec = 0;
    int n_err = 0;

    riscv_core_muldiv #(.XLEN(64)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_md_valid  (md_valid),
        .i_md_op     (md_op),
        .i_md_isword (md_isword),
        .i_md_srcA   (src_a),
        .i_md_srcB   (src_b),
        .i_md_flush  (md_flush),
        .o_md_ready  (md_ready),
        .o_md_busy   (md_busy),
        .o_md_done   (md_done),
        .o_md_result (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and wait (bounded) for done; lat counts from the accept edge, -1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res, output int lat);
        @(negedge clk);
        md_valid = 1'b1; md_op = op; md_isword = w; src_a = a; src_b = b;
        @(posedge clk); #1;
        md_valid = 1'b0;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 200; k++) begin
            if (md_done) begin
                lat = k;
                res = md_result;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; md_valid = 1'b0; md_op = 3'd0; md_isword = 1'b0;
        src_a = '0; src_b = '0; md_flush = 1'b0;
        #1;
        n_vec++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", md_ready); end
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", md_busy); end
        n_vec++; if (md_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", md_done); end
        n_vec++; if (md_result !== 64'd0) begin n_err++; $display("FAIL reset_result got %h want 0", md_result); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul();
        vec_t        tv [7];
        logic [63:0] res;
        int          lat;
        tv = '{
            '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd2},
            '{3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 8'd2},
            '{3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 8'd2},
            '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 8'd2},
            '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd2},
            '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 8'd2},
            '{3'd3, 1'b1, 64'h0000_0001_0000_0003, 64'd5, 64'd15, 8'd2}
        };
        foreach (tv[i]) begin
            run_op(tv[i].op, tv[i].w, tv[i].a, tv[i].b, res, lat);
            n_vec++;
            if (res !== tv[i].exp) begin n_err++; $display("FAIL mul[%0d] result got %h want %h", i, res, tv[i].exp); end
            n_vec++;
            if (lat != int'(tv[i].lat)) begin n_err++; $display("FAIL mul[%0d] latency got %0d want %0d", i, lat, tv[i].lat); end
        end
    endtask

    task automatic test_div();
        vec_t        tv [12];
        logic [63:0] res;
        int          lat;
        tv = '{
            '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd65},
            '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd65},
            '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 8'd65},
            '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 8'd65},
            '{3'd4, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 8'd65},
            '{3'd6, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 8'd65},
            '{3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 8'd65},
            '{3'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 8'd65},
            '{3'd5, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'd65},
            '{3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd33},
            '{3'd7, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd2, 8'd33},
            '{3'd5, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 8'd33}
        };
        foreach (tv[i]) begin
            run_op(tv[i].op, tv[i].w, tv[i].a, tv[i].b, res, lat);
            n_vec++;
            if (res !== tv[i].exp) begin n_err++; $display("FAIL div[%0d] result got %h want %h", i, res, tv[i].exp); end
            n_vec++;
            if (lat != int'(tv[i].lat)) begin n_err++; $display("FAIL div[%0d] latency got %0d want %0d", i, lat, tv[i].lat); end
        end
    endtask

    task automatic test_special();
        vec_t        tv [9];
        logic [63:0] res;
        int          lat;
        tv = '{
            '{3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1},
            '{3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1},
            '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 8'd1},
            '{3'd7, 1'b1, 64'h0000_0001_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 8'd1},
            '{3'd5, 1'b1, 64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1},
            '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 8'd1},
            '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'd1},
            '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 8'd1},
            '{3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 8'd1}
        };
        foreach (tv[i]) begin
            run_op(tv[i].op, tv[i].w, tv[i].a, tv[i].b, res, lat);
            n_vec++;
            if (res !== tv[i].exp) begin n_err++; $display("FAIL special[%0d] result got %h want %h", i, res, tv[i].exp); end
            n_vec++;
            if (lat != int'(tv[i].lat)) begin n_err++; $display("FAIL special[%0d] latency got %0d want %0d", i, lat, tv[i].lat); end
        end
    endtask

    // A competing MUL request is held on valid for the whole DIVU; only the DIVU must complete.
    task automatic test_busy_valid();
        int          lat;
        int          extra;
        logic [63:0] res;
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd5; md_isword = 1'b0; src_a = 64'd100; src_b = 64'd7;
        @(posedge clk); #1;
        md_op = 3'd0; src_a = 64'd3; src_b = 64'd5;
        lat = -1; res = '0;
        for (int k = 1; k <= 200; k++) begin
            if (md_done) begin lat = k; res = md_result; break; end
            @(posedge clk); #1;
        end
        md_valid = 1'b0;
        n_vec++; if (res !== 64'd14) begin n_err++; $display("FAIL busy_valid result got %h want %h", res, 64'd14); end
        n_vec++; if (lat != 65) begin n_err++; $display("FAIL busy_valid latency got %0d want 65", lat); end
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (md_busy || md_done) extra++;
        end
        n_vec++; if (extra != 0) begin n_err++; $display("FAIL busy_valid_extra_op got %0d busy cycles want 0", extra); end
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int          lat;
        int          dones;
        run_op(3'd0, 1'b0, 64'd3, 64'd5, res, lat);
        n_vec++; if (res !== 64'd15) begin n_err++; $display("FAIL flush_pre_mul got %h want %h", res, 64'd15); end
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd4; md_isword = 1'b0;
        src_a = 64'hFFFF_FFFF_FFFF_FFF9; src_b = 64'd2;
        @(posedge clk); #1;
        md_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        md_flush = 1'b1;
        @(posedge clk); #1;
        md_flush = 1'b0;
        n_vec++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", md_ready); end
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", md_busy); end
        n_vec++; if (md_result !== 64'd15) begin n_err++; $display("FAIL flush_result got %h want %h", md_result, 64'd15); end
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            if (md_done) dones++;
            @(posedge clk); #1;
        end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL flush_late_done got %0d pulses want 0", dones); end
    endtask

    task automatic test_flush_valid_idle();
        int dones;
        @(negedge clk);
        md_valid = 1'b1; md_flush = 1'b1; md_op = 3'd0; md_isword = 1'b0; src_a = 64'd2; src_b = 64'd2;
        @(posedge clk); #1;
        md_valid = 1'b0; md_flush = 1'b0;
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL flush_valid_busy got %b want 0", md_busy); end
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (md_done) dones++;
        end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL flush_valid_done got %0d pulses want 0", dones); end
        n_vec++; if (md_result !== 64'd15) begin n_err++; $display("FAIL flush_valid_result got %h want %h", md_result, 64'd15); end
    endtask

    // Flush raised during the DONE cycle: that done is already committed and stays visible.
    task automatic test_flush_in_done();
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd6; md_isword = 1'b0; src_a = 64'd9; src_b = 64'd0;
        @(posedge clk); #1;
        md_valid = 1'b0;
        md_flush = 1'b1;
        #1;
        n_vec++; if (md_done !== 1'b1) begin n_err++; $display("FAIL flush_done_pulse got %b want 1", md_done); end
        n_vec++; if (md_result !== 64'd9) begin n_err++; $display("FAIL flush_done_result got %h want %h", md_result, 64'd9); end
        @(posedge clk); #1;
        md_flush = 1'b0;
        n_vec++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL flush_done_ready got %b want 1", md_ready); end
    endtask

    task automatic test_reset_mid_div();
        int dones;
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd5; md_isword = 1'b0; src_a = 64'd100; src_b = 64'd7;
        @(posedge clk); #1;
        md_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_vec++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL rst_div_ready got %b want 1", md_ready); end
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL rst_div_busy got %b want 0", md_busy); end
        n_vec++; if (md_done !== 1'b0) begin n_err++; $display("FAIL rst_div_done got %b want 0", md_done); end
        n_vec++; if (md_result !== 64'd0) begin n_err++; $display("FAIL rst_div_result got %h want 0", md_result); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (md_done || md_busy) dones++;
        end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL rst_div_late_done got %0d cycles want 0", dones); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_busy_valid();
        test_flush();
        test_flush_valid_idle();
        test_flush_in_done();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
